// File: rtl/id_ex_ctl.sv
// id_ex_ctl: main-control decode of the IF/ID instruction plus the ID/EX
// pipeline register. Inserts a bubble on branch flush, an invalid slot, an
// unknown opcode or a load-use hazard, and counts hazard bubbles (saturating).
module id_ex_ctl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [1:0]       ex_alu_op_o,
  output logic [5:0]       ex_funct_o,
  output logic             ex_reg_dst_o,
  output logic             ex_alu_src_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             ex_mem_to_reg_o,
  output logic             ex_reg_write_o,
  output logic             ex_branch_o,
  output logic             ex_jump_o,
  output logic [4:0]       ex_rs_o,
  output logic [4:0]       ex_rt_o,
  output logic [4:0]       ex_rd_o,
  output logic [31:0]      ex_imm_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  logic [5:0] w_opcode;
  logic       w_known;
  logic [1:0] w_alu_op;
  logic       w_reg_dst, w_alu_src, w_mem_read, w_mem_write;
  logic       w_mem_to_reg, w_reg_write, w_branch, w_jump;
  logic       w_stall, w_bubble, w_load;

  logic             r_ex_valid;
  logic [1:0]       r_ex_alu_op;
  logic [5:0]       r_ex_funct;
  logic             r_ex_reg_dst, r_ex_alu_src, r_ex_mem_read, r_ex_mem_write;
  logic             r_ex_mem_to_reg, r_ex_reg_write, r_ex_branch, r_ex_jump;
  logic [4:0]       r_ex_rs, r_ex_rt, r_ex_rd;
  logic [31:0]      r_ex_imm;
  logic             r_illegal;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_opcode = instr_i[31:26];

  // Main-control decode of the ID instruction; unknown opcodes leave every control at 0.
  always_comb begin
    w_known      = 1'b1;
    w_alu_op     = 2'b00;
    w_reg_dst    = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_alu_op    = 2'b10;
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_LW: begin
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      OP_SW: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_BEQ: begin
        w_alu_op = 2'b01;
        w_branch = 1'b1;
      end
      OP_ADDI: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_J: begin
        w_jump = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
  end

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // A jump reads no registers, and a flushed slot is discarded anyway.
  assign w_stall = r_ex_valid & r_ex_mem_read & (r_ex_rt != 5'd0)
                 & ((r_ex_rt == instr_i[25:21]) | (r_ex_rt == instr_i[20:16]))
                 & instr_valid_i & (w_opcode != OP_J) & ~flush_i;

  assign w_bubble = flush_i | ~instr_valid_i | w_stall;
  assign w_load   = ~w_bubble & w_known;

  // ID/EX register: controls only pass for a loaded legal instruction; fields always follow instr_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid      <= 1'b0;
      r_ex_alu_op     <= 2'b00;
      r_ex_funct      <= 6'd0;
      r_ex_reg_dst    <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_branch     <= 1'b0;
      r_ex_jump       <= 1'b0;
      r_ex_rs         <= 5'd0;
      r_ex_rt         <= 5'd0;
      r_ex_rd         <= 5'd0;
      r_ex_imm        <= 32'd0;
      r_illegal       <= 1'b0;
    end else begin
      r_ex_funct      <= instr_i[5:0];
      r_ex_rs         <= instr_i[25:21];
      r_ex_rt         <= instr_i[20:16];
      r_ex_rd         <= instr_i[15:11];
      r_ex_imm        <= {{16{instr_i[15]}}, instr_i[15:0]};
      r_ex_valid      <= w_load;
      r_ex_alu_op     <= w_load ? w_alu_op : 2'b00;
      r_ex_reg_dst    <= w_load & w_reg_dst;
      r_ex_alu_src    <= w_load & w_alu_src;
      r_ex_mem_read   <= w_load & w_mem_read;
      r_ex_mem_write  <= w_load & w_mem_write;
      r_ex_mem_to_reg <= w_load & w_mem_to_reg;
      r_ex_reg_write  <= w_load & w_reg_write;
      r_ex_branch     <= w_load & w_branch;
      r_ex_jump       <= w_load & w_jump;
      r_illegal       <= ~w_bubble & ~w_known;
    end
  end

  // Saturating count of hazard bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_o         = w_stall;
  assign ex_valid_o      = r_ex_valid;
  assign ex_alu_op_o     = r_ex_alu_op;
  assign ex_funct_o      = r_ex_funct;
  assign ex_reg_dst_o    = r_ex_reg_dst;
  assign ex_alu_src_o    = r_ex_alu_src;
  assign ex_mem_read_o   = r_ex_mem_read;
  assign ex_mem_write_o  = r_ex_mem_write;
  assign ex_mem_to_reg_o = r_ex_mem_to_reg;
  assign ex_reg_write_o  = r_ex_reg_write;
  assign ex_branch_o     = r_ex_branch;
  assign ex_jump_o       = r_ex_jump;
  assign ex_rs_o         = r_ex_rs;
  assign ex_rt_o         = r_ex_rt;
  assign ex_rd_o         = r_ex_rd;
  assign ex_imm_o        = r_ex_imm;
  assign illegal_o       = r_illegal;
  assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_ctl.sv
// Bench for id_ex_ctl: table of directed vectors with hand-computed results,
// plus hand-written reset, reset-mid-stall and counter-saturation sequences.
module tb_id_ex_ctl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        flush_i;

  logic        stall_o, ex_valid_o, ex_reg_dst_o, ex_alu_src_o, ex_mem_read_o;
  logic        ex_mem_write_o, ex_mem_to_reg_o, ex_reg_write_o, ex_branch_o, ex_jump_o;
  logic [1:0]  ex_alu_op_o;
  logic [5:0]  ex_funct_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic [31:0] ex_imm_o;
  logic        illegal_o;
  logic [15:0] stall_cnt_o;

  logic        s2_stall, s2_valid, s2_reg_dst, s2_alu_src, s2_mem_read;
  logic        s2_mem_write, s2_mem_to_reg, s2_reg_write, s2_branch, s2_jump;
  logic [1:0]  s2_alu_op;
  logic [5:0]  s2_funct;
  logic [4:0]  s2_rs, s2_rt, s2_rd;
  logic [31:0] s2_imm;
  logic        s2_illegal;
  logic [1:0]  s2_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_ctl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .flush_i(flush_i), .stall_o(stall_o), .ex_valid_o(ex_valid_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_funct_o(ex_funct_o), .ex_reg_dst_o(ex_reg_dst_o),
    .ex_alu_src_o(ex_alu_src_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_imm_o(ex_imm_o),
    .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  // Narrow-counter instance driven by the same inputs, for saturation.
  id_ex_ctl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .flush_i(flush_i), .stall_o(s2_stall), .ex_valid_o(s2_valid),
    .ex_alu_op_o(s2_alu_op), .ex_funct_o(s2_funct), .ex_reg_dst_o(s2_reg_dst),
    .ex_alu_src_o(s2_alu_src), .ex_mem_read_o(s2_mem_read),
    .ex_mem_write_o(s2_mem_write), .ex_mem_to_reg_o(s2_mem_to_reg),
    .ex_reg_write_o(s2_reg_write), .ex_branch_o(s2_branch), .ex_jump_o(s2_jump),
    .ex_rs_o(s2_rs), .ex_rt_o(s2_rt), .ex_rd_o(s2_rd), .ex_imm_o(s2_imm),
    .illegal_o(s2_illegal), .stall_cnt_o(s2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic        fl;
    logic        e_stall;
    logic        e_valid;
    logic [1:0]  e_alu;
    logic [7:0]  e_ctl;   // {reg_dst,alu_src,mem_read,mem_write,mem_to_reg,reg_write,branch,jump}
    logic [4:0]  e_rd;
    logic [5:0]  e_funct;
    logic [31:0] e_imm;
    logic        e_ill;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [31:0] ins, input logic v, input logic f,
                              input logic st, input logic ev, input logic [1:0] al,
                              input logic [7:0] ct, input logic [4:0] rd,
                              input logic [5:0] fn, input logic [31:0] im,
                              input logic il, input logic [15:0] cn);
    vec_t r;
    r.instr = ins; r.vld = v; r.fl = f; r.e_stall = st; r.e_valid = ev; r.e_alu = al;
    r.e_ctl = ct; r.e_rd = rd; r.e_funct = fn; r.e_imm = im; r.e_ill = il; r.e_cnt = cn;
    return r;
  endfunction

  function automatic logic [7:0] ctl_now();
    return {ex_reg_dst_o, ex_alu_src_o, ex_mem_read_o, ex_mem_write_o,
            ex_mem_to_reg_o, ex_reg_write_o, ex_branch_o, ex_jump_o};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input int idx);
    chk("rst_valid", idx, {31'd0, ex_valid_o}, 32'd0);
    chk("rst_ctl", idx, {24'd0, ctl_now()}, 32'd0);
    chk("rst_alu", idx, {30'd0, ex_alu_op_o}, 32'd0);
    chk("rst_fields", idx, {ex_funct_o, ex_rs_o, ex_rt_o, ex_rd_o}, 32'd0);
    chk("rst_imm", idx, ex_imm_o, 32'd0);
    chk("rst_ill", idx, {31'd0, illegal_o}, 32'd0);
    chk("rst_cnt", idx, {16'd0, stall_cnt_o}, 32'd0);
  endtask

  localparam logic [31:0] ADD3  = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] SW5   = 32'hACC5FFFC; // sw $5,-4($6)
  localparam logic [31:0] BEQ   = 32'h10220008; // beq $1,$2,8
  localparam logic [31:0] ADDI  = 32'h20070005; // addi $7,$0,5
  localparam logic [31:0] JMP   = 32'h08000100; // j 0x100
  localparam logic [31:0] JMP2  = 32'h08400000; // j with bits[25:21]=2
  localparam logic [31:0] LW2   = 32'h8C220000; // lw $2,0($1)
  localparam logic [31:0] ADD4  = 32'h00432020; // add $4,$2,$3
  localparam logic [31:0] SW2   = 32'hACA20000; // sw $2,0($5)
  localparam logic [31:0] LW0   = 32'h8C200000; // lw $0,0($1)
  localparam logic [31:0] ADD0  = 32'h00002020; // add $4,$0,$0
  localparam logic [31:0] ILL   = 32'hFC000000; // opcode 0x3F

  initial begin
    logic [31:0] w;
    tbl[0]  = mk(ADD3, 1, 0, 0, 1, 2'b10, 8'h84, 5'd3,  6'h20, 32'h00001820, 0, 0);
    tbl[1]  = mk(SW5,  1, 0, 0, 1, 2'b00, 8'h50, 5'd31, 6'h3C, 32'hFFFFFFFC, 0, 0);
    tbl[2]  = mk(BEQ,  1, 0, 0, 1, 2'b01, 8'h02, 5'd0,  6'h08, 32'h00000008, 0, 0);
    tbl[3]  = mk(ADDI, 1, 0, 0, 1, 2'b00, 8'h44, 5'd0,  6'h05, 32'h00000005, 0, 0);
    tbl[4]  = mk(JMP,  1, 0, 0, 1, 2'b00, 8'h01, 5'd0,  6'h00, 32'h00000100, 0, 0);
    tbl[5]  = mk(LW2,  1, 0, 0, 1, 2'b00, 8'h6C, 5'd0,  6'h00, 32'h00000000, 0, 0);
    tbl[6]  = mk(ADD4, 1, 0, 1, 0, 2'b00, 8'h00, 5'd4,  6'h20, 32'h00002020, 0, 1);
    tbl[7]  = mk(ADD4, 1, 0, 0, 1, 2'b10, 8'h84, 5'd4,  6'h20, 32'h00002020, 0, 1);
    tbl[8]  = mk(LW2,  1, 0, 0, 1, 2'b00, 8'h6C, 5'd0,  6'h00, 32'h00000000, 0, 1);
    tbl[9]  = mk(ADD4, 1, 1, 0, 0, 2'b00, 8'h00, 5'd4,  6'h20, 32'h00002020, 0, 1);
    tbl[10] = mk(LW2,  1, 0, 0, 1, 2'b00, 8'h6C, 5'd0,  6'h00, 32'h00000000, 0, 1);
    tbl[11] = mk(ADD4, 0, 0, 0, 0, 2'b00, 8'h00, 5'd4,  6'h20, 32'h00002020, 0, 1);
    tbl[12] = mk(LW2,  1, 0, 0, 1, 2'b00, 8'h6C, 5'd0,  6'h00, 32'h00000000, 0, 1);
    tbl[13] = mk(SW2,  1, 0, 1, 0, 2'b00, 8'h00, 5'd0,  6'h00, 32'h00000000, 0, 2);
    tbl[14] = mk(SW2,  1, 0, 0, 1, 2'b00, 8'h50, 5'd0,  6'h00, 32'h00000000, 0, 2);
    tbl[15] = mk(LW2,  1, 0, 0, 1, 2'b00, 8'h6C, 5'd0,  6'h00, 32'h00000000, 0, 2);
    tbl[16] = mk(JMP2, 1, 0, 0, 1, 2'b00, 8'h01, 5'd0,  6'h00, 32'h00000000, 0, 2);
    tbl[17] = mk(LW0,  1, 0, 0, 1, 2'b00, 8'h6C, 5'd0,  6'h00, 32'h00000000, 0, 2);
    tbl[18] = mk(ADD0, 1, 0, 0, 1, 2'b10, 8'h84, 5'd4,  6'h20, 32'h00002020, 0, 2);
    tbl[19] = mk(ILL,  1, 0, 0, 0, 2'b00, 8'h00, 5'd0,  6'h00, 32'h00000000, 1, 2);
    tbl[20] = mk(ADDI, 1, 0, 0, 1, 2'b00, 8'h44, 5'd0,  6'h05, 32'h00000005, 0, 2);
    tbl[21] = mk(ILL,  1, 1, 0, 0, 2'b00, 8'h00, 5'd0,  6'h00, 32'h00000000, 0, 2);

    // Reset held with random instructions: everything stays 0.
    rst_n = 1'b0; instr_i = 32'd0; instr_valid_i = 1'b0; flush_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      instr_i = $urandom; instr_valid_i = 1'b1;
      chk_all_zero(c);
      $display("reset cycle %0d instr=%08h", c, instr_i);
    end
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      instr_i = tbl[i].instr; instr_valid_i = tbl[i].vld; flush_i = tbl[i].fl;
      #3;
      chk("stall", i, {31'd0, stall_o}, {31'd0, tbl[i].e_stall});
      @(posedge clk); #1;
      w = tbl[i].instr;
      chk("valid", i, {31'd0, ex_valid_o}, {31'd0, tbl[i].e_valid});
      chk("alu_op", i, {30'd0, ex_alu_op_o}, {30'd0, tbl[i].e_alu});
      chk("ctl", i, {24'd0, ctl_now()}, {24'd0, tbl[i].e_ctl});
      chk("rd", i, {27'd0, ex_rd_o}, {27'd0, tbl[i].e_rd});
      chk("rs_rt", i, {22'd0, ex_rs_o, ex_rt_o}, {22'd0, w[25:21], w[20:16]});
      chk("funct", i, {26'd0, ex_funct_o}, {26'd0, tbl[i].e_funct});
      chk("imm", i, ex_imm_o, tbl[i].e_imm);
      chk("illegal", i, {31'd0, illegal_o}, {31'd0, tbl[i].e_ill});
      chk("cnt", i, {16'd0, stall_cnt_o}, {16'd0, tbl[i].e_cnt});
      $display("vec %0d instr=%08h v=%0b f=%0b stall=%0b ex_valid=%0b ctl=%02h alu=%0d ill=%0b cnt=%0d",
               i, tbl[i].instr, tbl[i].vld, tbl[i].fl, stall_o, ex_valid_o, ctl_now(),
               ex_alu_op_o, illegal_o, stall_cnt_o);
    end

    // Reset asserted in the middle of a stall cycle.
    instr_i = LW2; instr_valid_i = 1'b1; flush_i = 1'b0;
    @(posedge clk); #1;
    instr_i = ADD4;
    #3;
    chk("midrst_stall_before", 0, {31'd0, stall_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero(100);
    chk("midrst_stall_after", 0, {31'd0, stall_o}, 32'd0);
    chk("midrst_cnt2", 0, {30'd0, s2_cnt}, 32'd0);
    $display("reset mid-stall: ex_valid=%0b stall=%0b cnt=%0d", ex_valid_o, stall_o, stall_cnt_o);
    @(posedge clk); #1;
    rst_n = 1'b1; instr_valid_i = 1'b0;

    // Five load-use stalls: the 2-bit counter saturates at 3.
    for (int k = 1; k <= 5; k++) begin
      instr_i = LW2; instr_valid_i = 1'b1;
      @(posedge clk); #1;
      instr_i = ADD4;
      #3;
      chk("sat_stall", k, {31'd0, s2_stall}, 32'd1);
      @(posedge clk); #1;
      chk("sat_cnt2", k, {30'd0, s2_cnt}, (k > 3) ? 32'd3 : k);
      chk("sat_cnt16", k, {16'd0, stall_cnt_o}, k);
      $display("stall %0d: cnt2=%0d cnt16=%0d", k, s2_cnt, stall_cnt_o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
